// File: rtl/spi_word_framer.sv
// spi_word_framer
//   Bridges the SPI slave byte driver and the PU-side word buffers.
//   Received bytes are packed MSB-first into DATA_WIDTH words (word_rx +
//   one-cycle word_rx_valid). Outgoing words are unpacked MSB-first onto
//   byte_tx, with word_tx_ready pulsing in the cycle a word is taken.
//   Frame boundaries come from the synchronized active-low cs.
// Ports:
//   clk, rst (async, active-low), cs (async, active-low chip select)
//   byte_rx / byte_rx_valid     : byte from the driver, one pulse per exchange
//   byte_tx                     : byte shifted out on the next exchange
//   word_rx / word_rx_valid     : assembled word, one-cycle strobe
//   word_tx / word_tx_valid     : next word to send; word_tx_ready = consumed
//   frame_start / frame_done    : one-cycle frame boundary pulses
//   word_count, overflow, partial : per-frame status, held until next start
module spi_word_framer #(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int BUF_SIZE       = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cs,
  input  logic [SPI_DATA_WIDTH-1:0]         byte_rx,
  input  logic                              byte_rx_valid,
  output logic [SPI_DATA_WIDTH-1:0]         byte_tx,
  output logic [DATA_WIDTH-1:0]             word_rx,
  output logic                              word_rx_valid,
  input  logic [DATA_WIDTH-1:0]             word_tx,
  input  logic                              word_tx_valid,
  output logic                              word_tx_ready,
  output logic                              frame_start,
  output logic                              frame_done,
  output logic [$clog2(BUF_SIZE+1)-1:0]     word_count,
  output logic                              overflow,
  output logic                              partial
);

  localparam int BYTES = DATA_WIDTH / SPI_DATA_WIDTH;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = $clog2(BUF_SIZE + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic                    cs_meta_q, cs_s_q, cs_prev_q;
  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   word_rx_q, word_rx_d;
  logic                    word_rx_valid_q, word_rx_valid_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_done_q, frame_done_d;
  logic [CW-1:0]           word_count_q, word_count_d;
  logic                    overflow_q, overflow_d;
  logic                    partial_q, partial_d;

  logic                    cs_fall, cs_rise, last_byte;
  logic [DATA_WIDTH-1:0]   rx_next;

  assign cs_fall   = cs_prev_q & ~cs_s_q;
  assign cs_rise   = ~cs_prev_q & cs_s_q;
  assign last_byte = (byte_cnt_q == BCW'(BYTES - 1));
  assign rx_next   = (rx_shift_q << SPI_DATA_WIDTH) | DATA_WIDTH'(byte_rx);

  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    word_rx_d       = word_rx_q;
    word_rx_valid_d = 1'b0;
    frame_start_d   = 1'b0;
    frame_done_d    = 1'b0;
    word_count_d    = word_count_q;
    overflow_d      = overflow_q;
    partial_d       = partial_q;
    word_tx_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          word_count_d  = '0;
          overflow_d    = 1'b0;
          partial_d     = 1'b0;
          byte_cnt_d    = '0;
          rx_shift_d    = '0;
          tx_shift_d    = word_tx_valid ? word_tx : '0;
          word_tx_ready = word_tx_valid;
        end
      end
      ACTIVE: begin
        if (byte_rx_valid) begin
          rx_shift_d = rx_next;
          tx_shift_d = tx_shift_q << SPI_DATA_WIDTH;
          if (last_byte) begin
            byte_cnt_d    = '0;
            tx_shift_d    = word_tx_valid ? word_tx : '0;
            word_tx_ready = word_tx_valid;
            if (word_count_q < CW'(BUF_SIZE)) begin
              word_rx_d       = rx_next;
              word_rx_valid_d = 1'b1;
              word_count_d    = word_count_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        // A byte arriving with the closing edge is counted first, so the
        // partial decision uses the post-byte index.
        if (cs_rise) begin
          frame_done_d = 1'b1;
          if (byte_cnt_d != '0) partial_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cs_meta_q       <= 1'b1;
      cs_s_q          <= 1'b1;
      cs_prev_q       <= 1'b1;
      byte_cnt_q      <= '0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      word_rx_q       <= '0;
      word_rx_valid_q <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_done_q    <= 1'b0;
      word_count_q    <= '0;
      overflow_q      <= 1'b0;
      partial_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cs_meta_q       <= cs;
      cs_s_q          <= cs_meta_q;
      cs_prev_q       <= cs_s_q;
      byte_cnt_q      <= byte_cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      word_rx_q       <= word_rx_d;
      word_rx_valid_q <= word_rx_valid_d;
      frame_start_q   <= frame_start_d;
      frame_done_q    <= frame_done_d;
      word_count_q    <= word_count_d;
      overflow_q      <= overflow_d;
      partial_q       <= partial_d;
    end
  end

  assign byte_tx       = tx_shift_q[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
  assign word_rx       = word_rx_q;
  assign word_rx_valid = word_rx_valid_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign word_count    = word_count_q;
  assign overflow      = overflow_q;
  assign partial       = partial_q;

endmodule

// File: tb/tb_spi_word_framer.sv
module tb_spi_word_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1;
  logic [7:0]  byte_rx = '0;
  logic        byte_rx_valid = 1'b0;
  logic [7:0]  byte_tx;
  logic [31:0] word_rx;
  logic        word_rx_valid;
  logic [31:0] word_tx = '0;
  logic        word_tx_valid = 1'b0;
  logic        word_tx_ready;
  logic        frame_start, frame_done;
  logic [2:0]  word_count;
  logic        overflow, partial;

  spi_word_framer #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .BUF_SIZE(6)) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .byte_rx(byte_rx), .byte_rx_valid(byte_rx_valid), .byte_tx(byte_tx),
    .word_rx(word_rx), .word_rx_valid(word_rx_valid),
    .word_tx(word_tx), .word_tx_valid(word_tx_valid), .word_tx_ready(word_tx_ready),
    .frame_start(frame_start), .frame_done(frame_done),
    .word_count(word_count), .overflow(overflow), .partial(partial)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; int cyc; } wexp_t;
  typedef struct { logic [2:0] cnt; logic ovf; logic part; } fexp_t;

  wexp_t      wq[$];
  fexp_t      fq[$];
  logic [7:0] bq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fs_cnt = 0;
  int rdy_cnt = 0;
  int last_fd_cyc = -1;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void flag(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: event seen with nothing expected", name);
  endfunction

  // Monitor: registered outputs just after posedge, byte_tx/ready just after negedge.
  initial begin
    wexp_t we;
    fexp_t fe;
    forever begin
      @(posedge clk); #1;
      if (word_rx_valid) begin
        if (wq.size() == 0) flag("word_rx_valid");
        else begin
          we = wq.pop_front();
          chk("word_rx", word_rx, we.w);
          chk("word_rx_latency", cyc, we.cyc);
        end
      end
      if (frame_done) begin
        last_fd_cyc = cyc;
        if (fq.size() == 0) flag("frame_done");
        else begin
          fe = fq.pop_front();
          chk("word_count", {29'd0, word_count}, {29'd0, fe.cnt});
          chk("overflow", {31'd0, overflow}, {31'd0, fe.ovf});
          chk("partial", {31'd0, partial}, {31'd0, fe.part});
        end
      end
      if (frame_start) fs_cnt = fs_cnt + 1;
      @(negedge clk); #1;
      if (byte_rx_valid) begin
        if (bq.size() == 0) flag("byte_tx");
        else chk("byte_tx", {24'd0, byte_tx}, {24'd0, bq.pop_front()});
      end
      if (word_tx_ready) rdy_cnt = rdy_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic [7:0] etx,
                           input bit completes, input logic [31:0] w);
    wexp_t e;
    bq.push_back(etx);
    if (completes) begin
      e.w = w; e.cyc = cyc + 1;
      wq.push_back(e);
    end
    byte_rx = b;
    byte_rx_valid = 1'b1;
    @(negedge clk);
    byte_rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] tx, input bit expect_out);
    send_byte(w[31:24], tx[31:24], 1'b0, w);
    send_byte(w[23:16], tx[23:16], 1'b0, w);
    send_byte(w[15:8],  tx[15:8],  1'b0, w);
    send_byte(w[7:0],   tx[7:0],   expect_out, w);
  endtask

  task automatic frame_begin();
    int base;
    base = fs_cnt;
    cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("frame_start", fs_cnt - base, 1);
  endtask

  task automatic frame_end(input logic [2:0] cnt, input logic ovf, input logic part);
    fexp_t f;
    f.cnt = cnt; f.ovf = ovf; f.part = part;
    fq.push_back(f);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && (wq.size() + fq.size() + bq.size()) != 0; i++)
      @(negedge clk);
    if ((wq.size() + fq.size() + bq.size()) != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_drain: %0d words, %0d frames, %0d bytes still expected",
               name, wq.size(), fq.size(), bq.size());
      wq.delete(); fq.delete(); bq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_tx"}, {24'd0, byte_tx}, 32'd0);
    chk({tag, "_word_rx"}, word_rx, 32'd0);
    chk({tag, "_word_rx_valid"}, {31'd0, word_rx_valid}, 32'd0);
    chk({tag, "_word_tx_ready"}, {31'd0, word_tx_ready}, 32'd0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_word_count"}, {29'd0, word_count}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_partial"}, {31'd0, partial}, 32'd0);
  endtask

  initial begin
    int base;
    int coinc_cyc;
    // Reset
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single word, nothing to transmit
    base = rdy_cnt;
    frame_begin();
    send_word(32'hDEADBEEF, 32'h0, 1'b1);
    frame_end(3'd1, 1'b0, 1'b0);
    drain("single");
    chk("single_ready_count", rdy_cnt - base, 0);

    // Transmit
    word_tx = 32'h11223344;
    word_tx_valid = 1'b1;
    base = rdy_cnt;
    frame_begin();
    chk("tx_ready_at_start", rdy_cnt - base, 1);
    word_tx = 32'h55667788;
    send_word(32'h01020304, 32'h11223344, 1'b1);
    chk("tx_ready_after_word", rdy_cnt - base, 2);
    word_tx_valid = 1'b0;
    frame_end(3'd1, 1'b0, 1'b0);
    drain("transmit");

    // Overflow: seven words into a six-word frame
    frame_begin();
    for (int i = 0; i < 7; i++)
      send_word(32'h01020304 * (i + 1), 32'h0, i < 6);
    frame_end(3'd6, 1'b1, 1'b0);
    drain("overflow");

    // Partial: six bytes
    frame_begin();
    send_word(32'hA1A2A3A4, 32'h0, 1'b1);
    send_byte(8'hA5, 8'h00, 1'b0, 32'h0);
    send_byte(8'hA6, 8'h00, 1'b0, 32'h0);
    frame_end(3'd1, 1'b0, 1'b1);
    drain("partial");

    // Edge coincidence; its start also clears the partial flag
    frame_begin();
    chk("partial_cleared", {31'd0, partial}, 32'd0);
    chk("word_count_cleared", {29'd0, word_count}, 32'd0);
    send_byte(8'hC0, 8'h00, 1'b0, 32'h0);
    send_byte(8'hFF, 8'h00, 1'b0, 32'h0);
    send_byte(8'hEE, 8'h00, 1'b0, 32'h0);
    fq.push_back('{cnt: 3'd1, ovf: 1'b0, part: 1'b0});
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    coinc_cyc = cyc + 1;
    send_byte(8'h11, 8'h00, 1'b1, 32'hC0FFEE11);
    repeat (3) @(negedge clk);
    drain("coincide");
    chk("coincide_frame_done_cycle", last_fd_cyc, coinc_cyc);

    // Reset mid-frame after two bytes
    word_tx = 32'hAABBCCDD;
    word_tx_valid = 1'b1;
    frame_begin();
    send_byte(8'h12, 8'hAA, 1'b0, 32'h0);
    send_byte(8'h34, 8'hBB, 1'b0, 32'h0);
    word_tx_valid = 1'b0;
    rst = 1'b0;
    cs = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    frame_begin();
    send_word(32'hDEADBEEF, 32'h0, 1'b1);
    frame_end(3'd1, 1'b0, 1'b0);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
